// File: rtl/image_pkg.sv
// Shared encodings for the image pattern generator: pattern modes and FSM states.
package image_pkg;

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC_S,
    VBLANK_S,
    ACTIVE,
    HBLANK_S,
    DONE
  } state_e;

  localparam int FRAME_CNT_W = 16;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/image_pattern_gen_pixel.sv
// One pixel lane: maps (x, y, mode, frame count) to an RGB value.
module pattern_pixel
  import image_pkg::*;
#(
  parameter int WIDTH   = 768,
  parameter int DATA_W  = 8,
  parameter int SQ_LOG2 = 4,
  parameter int XW      = $clog2(WIDTH + 1),
  parameter int YW      = 10
) (
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  mode_e                  mode,
  input  logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [DATA_W-1:0]      R,
  output logic [DATA_W-1:0]      G,
  output logic [DATA_W-1:0]      B
);

  logic [31:0] xe, ye;
  logic [2:0]  bar;

  // Widen coordinates so the square-size bit select and bar division never go out of range.
  assign xe  = 32'(x);
  assign ye  = 32'(y);
  assign bar = 3'((xe * 32'd8) / 32'(WIDTH));

  // Pattern select; every arithmetic result is truncated to the channel width.
  always_comb begin
    R = '0;
    G = '0;
    B = '0;
    case (mode)
      MODE_GRAD: begin
        R = DATA_W'(xe);
        G = DATA_W'(ye);
        B = DATA_W'(xe + ye);
      end
      MODE_BARS: begin
        R = bar[2] ? '1 : '0;
        G = bar[1] ? '1 : '0;
        B = bar[0] ? '1 : '0;
      end
      MODE_CHECK: begin
        if (xe[SQ_LOG2] ^ ye[SQ_LOG2]) begin
          R = '1;
          G = '1;
          B = '1;
        end
      end
      default: begin
        R = DATA_W'(frame_cnt);
        G = DATA_W'(frame_cnt);
        B = DATA_W'(frame_cnt);
      end
    endcase
  end

endmodule

// File: rtl/image_pattern_gen.sv
// Frame sequencer: VSYNC, vertical blank, active lines with backpressure,
// horizontal blank per line, and a done pulse. Pixel data and HSYNC are registered
// from next-state values so the first ACTIVE cycle already carries pixel x=0.
module image_pattern_gen
  import image_pkg::*;
#(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int PIX_PER_CLK = 2,
  parameter int DATA_W      = 8,
  parameter int HBLANK      = 160,
  parameter int VBLANK      = 20,
  parameter int SQ_LOG2     = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic                          ready,
  output logic                          VSYNC,
  output logic                          HSYNC,
  output logic [PIX_PER_CLK*DATA_W-1:0] DATA_R,
  output logic [PIX_PER_CLK*DATA_W-1:0] DATA_G,
  output logic [PIX_PER_CLK*DATA_W-1:0] DATA_B,
  output logic                          ctrl_done,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_cnt
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int BW = cnt_w((HBLANK > VBLANK) ? HBLANK : VBLANK);

  if ((WIDTH % PIX_PER_CLK) != 0 || (WIDTH % 8) != 0) begin : g_bad_width
    $error("image_pattern_gen: WIDTH must be a multiple of PIX_PER_CLK and of 8");
  end
  if (PIX_PER_CLK != 1 && PIX_PER_CLK != 2 && PIX_PER_CLK != 4) begin : g_bad_ppc
    $error("image_pattern_gen: PIX_PER_CLK must be 1, 2 or 4");
  end

  state_e                            state, state_n;
  mode_e                             mode_q, mode_n;
  logic [XW-1:0]                     x, x_n;
  logic [YW-1:0]                     y, y_n;
  logic [BW-1:0]                     bcnt, bcnt_n;
  logic                              last_line, line_end;
  logic [PIX_PER_CLK-1:0][DATA_W-1:0] r_n, g_n, b_n, r_q, g_q, b_q;
  logic                              hsync_q;

  assign last_line = (y == YW'(HEIGHT - 1));
  assign line_end  = (x == XW'(WIDTH - PIX_PER_CLK));

  // State, coordinate, blank-counter and mode registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      mode_q <= MODE_GRAD;
      x      <= '0;
      y      <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      x      <= x_n;
      y      <= y_n;
      bcnt   <= bcnt_n;
    end
  end

  // Next-state and counter update; a stalled ACTIVE beat leaves everything unchanged.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    x_n     = x;
    y_n     = y;
    bcnt_n  = bcnt;
    case (state)
      IDLE: if (start) begin
        state_n = VSYNC_S;
        mode_n  = mode_e'(mode);
        x_n     = '0;
        y_n     = '0;
      end
      VSYNC_S: begin
        bcnt_n  = '0;
        state_n = (VBLANK > 0) ? VBLANK_S : ACTIVE;
      end
      VBLANK_S: begin
        if (bcnt == BW'(VBLANK - 1)) state_n = ACTIVE;
        else                         bcnt_n  = bcnt + BW'(1);
      end
      ACTIVE: if (ready) begin
        if (line_end) begin
          x_n    = '0;
          bcnt_n = '0;
          if (HBLANK > 0)     state_n = HBLANK_S;
          else if (last_line) state_n = DONE;
          else                y_n     = y + YW'(1);
        end else begin
          x_n = x + XW'(PIX_PER_CLK);
        end
      end
      HBLANK_S: begin
        if (bcnt == BW'(HBLANK - 1)) begin
          if (last_line) state_n = DONE;
          else begin
            state_n = ACTIVE;
            y_n     = y + YW'(1);
          end
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        y_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar k = 0; k < PIX_PER_CLK; k++) begin : g_lane
    pattern_pixel #(
      .WIDTH  (WIDTH),
      .DATA_W (DATA_W),
      .SQ_LOG2(SQ_LOG2),
      .XW     (XW),
      .YW     (YW)
    ) u_pix (
      .x        (x_n + XW'(k)),
      .y        (y_n),
      .mode     (mode_q),
      .frame_cnt(frame_cnt),
      .R        (r_n[k]),
      .G        (g_n[k]),
      .B        (b_n[k])
    );
  end

  // Registered beat: valid and data follow the state being entered, zero outside ACTIVE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hsync_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= (state_n == ACTIVE);
      r_q     <= (state_n == ACTIVE) ? r_n : '0;
      g_q     <= (state_n == ACTIVE) ? g_n : '0;
      b_q     <= (state_n == ACTIVE) ? b_n : '0;
    end
  end

  // Completed-frame counter, advanced as DONE is left.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)           frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
  end

  assign VSYNC     = (state == VSYNC_S);
  assign ctrl_done = (state == DONE);
  assign busy      = (state != IDLE);
  assign HSYNC     = hsync_q;
  assign DATA_R    = r_q;
  assign DATA_G    = g_q;
  assign DATA_B    = b_q;

endmodule

// File: tb/tb_image_pattern_gen.sv
// Directed bench for image_pattern_gen with an 8x4 frame, two pixels per beat.
module tb_image_pattern_gen;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        ready = 1'b1;
  logic        VSYNC, HSYNC, ctrl_done, busy;
  logic [15:0] DATA_R, DATA_G, DATA_B, frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] br[64], bg[64], bb[64];
  int nbeats, vs_cyc, done_cyc, nvs, ndone, stable_err;

  always #5 HCLK = ~HCLK;

  image_pattern_gen #(
    .WIDTH(8), .HEIGHT(4), .PIX_PER_CLK(2), .DATA_W(8),
    .HBLANK(2), .VBLANK(3), .SQ_LOG2(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .ready(ready),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .ctrl_done(ctrl_done), .busy(busy), .frame_cnt(frame_cnt)
  );

  // Starts one frame and records beats; cycle 0 is the first sample after start is taken.
  task automatic run_frame(input logic [1:0] m, input int stall_at, input int stall_len,
                           input int extra, input bit poke);
    int stall_left = 0;
    bit stall_used = 0;
    logic [15:0] hr = '0, hg = '0, hb = '0;
    nbeats = 0; vs_cyc = -1; done_cyc = -1; nvs = 0; ndone = 0; stable_err = 0;
    ready = 1'b1;
    @(negedge HCLK); mode = m; start = 1'b1;
    @(negedge HCLK); start = 1'b0;
    for (int c = 0; c < 150; c++) begin
      start = poke && (c == 5);
      if (VSYNC) begin nvs++; if (vs_cyc < 0) vs_cyc = c; end
      if (ctrl_done) begin ndone++; if (done_cyc < 0) done_cyc = c; end
      if (HSYNC && !stall_used && nbeats == stall_at) begin
        stall_used = 1; stall_left = stall_len;
        hr = DATA_R; hg = DATA_G; hb = DATA_B;
      end
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
        if (!HSYNC || DATA_R !== hr || DATA_G !== hg || DATA_B !== hb) stable_err++;
      end else begin
        ready = 1'b1;
      end
      if (HSYNC && ready && nbeats < 64) begin
        br[nbeats] = DATA_R; bg[nbeats] = DATA_G; bb[nbeats] = DATA_B;
        nbeats++;
      end
      if (done_cyc >= 0 && c >= done_cyc + extra) break;
      @(negedge HCLK);
    end
    ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({VSYNC, HSYNC, ctrl_done, busy, DATA_R, DATA_G, DATA_B, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: vs=%b hs=%b done=%b busy=%b R=%h G=%h B=%h fc=%0d, want all 0",
               VSYNC, HSYNC, ctrl_done, busy, DATA_R, DATA_G, DATA_B, frame_cnt);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ready = i[0]; mode = 2'(i);
      @(negedge HCLK);
      checks++;
      if ({VSYNC, HSYNC, ctrl_done, busy, DATA_R, DATA_G, DATA_B, frame_cnt} !== '0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: vs=%b hs=%b busy=%b R=%h fc=%0d, want all 0",
                 i, VSYNC, HSYNC, busy, DATA_R, frame_cnt);
      end
    end
    ready = 1'b1;
  endtask

  task automatic test_gradient();
    run_frame(2'd0, -1, 0, 5, 0);
    checks++; if (nbeats !== 16) begin errors++; $display("FAIL grad_beats: got %0d want 16", nbeats); end
    checks++; if (vs_cyc !== 0) begin errors++; $display("FAIL grad_vsync_cycle: got %0d want 0", vs_cyc); end
    checks++; if (done_cyc - vs_cyc !== 28) begin errors++; $display("FAIL grad_done_latency: got %0d want 28", done_cyc - vs_cyc); end
    checks++; if (nvs !== 1 || ndone !== 1) begin errors++; $display("FAIL grad_pulses: vs=%0d done=%0d want 1/1", nvs, ndone); end
    checks++; if (br[0] !== 16'h0100) begin errors++; $display("FAIL grad_b0_R: got %h want 0100", br[0]); end
    checks++; if (bg[0] !== 16'h0000) begin errors++; $display("FAIL grad_b0_G: got %h want 0000", bg[0]); end
    checks++; if (bg[4] !== 16'h0101) begin errors++; $display("FAIL grad_l1_G: got %h want 0101", bg[4]); end
    checks++; if (bb[4] !== 16'h0201) begin errors++; $display("FAIL grad_l1_B: got %h want 0201", bb[4]); end
    checks++; if (br[15] !== 16'h0706) begin errors++; $display("FAIL grad_last_R: got %h want 0706", br[15]); end
    checks++; if (bb[15] !== 16'h0a09) begin errors++; $display("FAIL grad_last_B: got %h want 0a09", bb[15]); end
    @(negedge HCLK);
    checks++; if (frame_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL grad_end: fc=%0d busy=%b want 1/0", frame_cnt, busy); end
  endtask

  task automatic test_backpressure();
    run_frame(2'd0, 9, 3, 5, 0);
    checks++; if (nbeats !== 16) begin errors++; $display("FAIL bp_beats: got %0d want 16", nbeats); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", stable_err); end
    checks++; if (done_cyc - vs_cyc !== 31) begin errors++; $display("FAIL bp_done_latency: got %0d want 31", done_cyc - vs_cyc); end
    checks++; if (br[9] !== 16'h0302 || bg[9] !== 16'h0202 || bb[9] !== 16'h0504) begin
      errors++; $display("FAIL bp_held_beat: R=%h G=%h B=%h want 0302/0202/0504", br[9], bg[9], bb[9]); end
    checks++; if (br[10] !== 16'h0504) begin errors++; $display("FAIL bp_next_beat: got %h want 0504", br[10]); end
    @(negedge HCLK);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_bars();
    run_frame(2'd1, -1, 0, 3, 0);
    checks++; if (br[2] !== 16'hffff || bg[2] !== 16'h0000 || bb[2] !== 16'hff00) begin
      errors++; $display("FAIL bars_x4: R=%h G=%h B=%h want ffff/0000/ff00", br[2], bg[2], bb[2]); end
    checks++; if (br[1] !== 16'h0000 || bg[1] !== 16'hffff || bb[1] !== 16'hff00) begin
      errors++; $display("FAIL bars_x2: R=%h G=%h B=%h want 0000/ffff/ff00", br[1], bg[1], bb[1]); end
    checks++; if (br[7] !== 16'hffff || bg[7] !== 16'hffff || bb[7] !== 16'hff00) begin
      errors++; $display("FAIL bars_x6: R=%h G=%h B=%h want ffff/ffff/ff00", br[7], bg[7], bb[7]); end
  endtask

  task automatic test_checker();
    run_frame(2'd2, -1, 0, 3, 0);
    checks++; if (br[1] !== 16'hffff || bg[1] !== 16'hffff || bb[1] !== 16'hffff) begin
      errors++; $display("FAIL chk_y0_x2: R=%h G=%h B=%h want ffff", br[1], bg[1], bb[1]); end
    checks++; if (br[9] !== 16'h0000 || bg[9] !== 16'h0000 || bb[9] !== 16'h0000) begin
      errors++; $display("FAIL chk_y2_x2: R=%h G=%h B=%h want 0000", br[9], bg[9], bb[9]); end
    checks++; if (br[0] !== 16'h0000) begin errors++; $display("FAIL chk_y0_x0: got %h want 0000", br[0]); end
    checks++; if (br[12] !== 16'hffff) begin errors++; $display("FAIL chk_y3_x0: got %h want ffff", br[12]); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    bit hit = 0;
    @(negedge HCLK); mode = 2'd0; start = 1'b1;
    @(negedge HCLK); start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (HSYNC) begin
        if (cnt == 9) hit = 1;
        else begin cnt++; @(negedge HCLK); end
      end else begin
        @(negedge HCLK);
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: got %0d beats want line 2", cnt); end
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({VSYNC, HSYNC, ctrl_done, busy, DATA_R, DATA_G, DATA_B, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: hs=%b busy=%b R=%h G=%h B=%h fc=%0d want all 0",
               HSYNC, busy, DATA_R, DATA_G, DATA_B, frame_cnt);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (busy !== 1'b0 || HSYNC !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy=%b hs=%b want 0/0", busy, HSYNC); end
  endtask

  task automatic test_back_to_back();
    run_frame(2'd3, -1, 0, 0, 0);
    checks++; if (br[0] !== 16'h0000 || bg[15] !== 16'h0000) begin
      errors++; $display("FAIL solid_f1: R0=%h G15=%h want 0000", br[0], bg[15]); end
    checks++; if (done_cyc !== 28) begin errors++; $display("FAIL solid_f1_done: got %0d want 28", done_cyc); end
    run_frame(2'd3, -1, 0, 0, 0);
    checks++; if (vs_cyc !== 0) begin errors++; $display("FAIL solid_f2_start: vsync at %0d want 0", vs_cyc); end
    checks++; if (br[0] !== 16'h0101 || bb[15] !== 16'h0101) begin
      errors++; $display("FAIL solid_f2: R0=%h B15=%h want 0101", br[0], bb[15]); end
    @(negedge HCLK);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL solid_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_busy_ignore();
    run_frame(2'd0, -1, 0, 10, 1);
    checks++; if (nvs !== 1 || ndone !== 1) begin
      errors++; $display("FAIL busy_start_ignored: vs=%0d done=%0d want 1/1", nvs, ndone); end
    checks++; if (nbeats !== 16) begin errors++; $display("FAIL busy_beats: got %0d want 16", nbeats); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL busy_frame_cnt: got %0d want 3", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_gradient();
    test_backpressure();
    test_bars();
    test_checker();
    test_reset_mid();
    test_back_to_back();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
